pit_timer: RTL

//  Programmable interval timer: 16-bit prescaler feeding a 16-bit divider, both

---
 rtl/pit_timer.sv | 107 ++++++++++
 1 files changed

// File: rtl/pit_timer.sv
// Programmable interval timer: down-counting prescaler feeding a down-counting
// divider, both auto-reloading. Emits a one-cycle tick per period and a latched
// interrupt that the CPU acknowledges. Live counts are readable through dout.
module pit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             wr_pre,
  input  logic             wr_div,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] dout,
  input  logic             irq_ack,
  output logic             tick,
  output logic             irq
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pre_rel_q, pre_rel_d;
  logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] div_rel_q, div_rel_d;
  logic [WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic             irq_q, irq_d;
  logic             din_nz;

  assign din_nz = (din != '0);

  // Next-state: CPU writes take priority and suppress counting for that cycle.
  always_comb begin
    state_d   = state_q;
    pre_rel_d = pre_rel_q;
    pre_cnt_d = pre_cnt_q;
    div_rel_d = div_rel_q;
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;

    if (wr_pre) begin
      pre_rel_d = din;
      pre_cnt_d = din;
    end

    if (wr_div) begin
      div_rel_d = din;
      div_cnt_d = din;
      if (din_nz) begin
        // Starting or restarting realigns the prescaler phase; a same-cycle
        // prescaler write already placed the fresh value in pre_cnt_d.
        state_d = RUN;
        if (!wr_pre) begin
          pre_cnt_d = pre_rel_q;
        end
      end else begin
        state_d = IDLE;
      end
    end

    if (!wr_pre && !wr_div && (state_q == RUN)) begin
      if (pre_cnt_q != '0) begin
        pre_cnt_d = pre_cnt_q - WIDTH'(1);
      end else begin
        pre_cnt_d = pre_rel_q;
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - WIDTH'(1);
        end else begin
          div_cnt_d = div_rel_q;
          tick_d    = 1'b1;
        end
      end
    end

    // A tick sets the interrupt even when acknowledged in the same cycle.
    irq_d = tick_q | (irq_q & ~irq_ack);
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_rel_q <= '0;
      pre_cnt_q <= '0;
      div_rel_q <= '0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_rel_q <= pre_rel_d;
      pre_cnt_q <= pre_cnt_d;
      div_rel_q <= div_rel_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      irq_q     <= irq_d;
    end
  end

  assign dout = rd_sel ? div_cnt_q : pre_cnt_q;
  assign tick = tick_q;
  assign irq  = irq_q;

endmodule
